// File: rtl/minimicro_pkg.sv
// Shared types and constants for the minimicro front end.
package minimicro_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  // Instruction word that marks an invalid fetch and stops the front end.
  localparam logic [31:0] FETCH_FAULT_WORD = 32'hDEADBEEF;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {instruction word, pc} between fetch and the consumer.
// Flush wins over push and pop. Outputs read zero whenever the queue is empty.
module fetch_queue #(
  parameter int DATA_LENGTH = 32,
  parameter int PW          = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [DATA_LENGTH-1:0] i_data,
  input  logic [PW-1:0]          i_pc,
  output logic [DATA_LENGTH-1:0] o_data,
  output logic [PW-1:0]          o_pc,
  output logic                   o_full,
  output logic                   o_empty
);

  logic [DATA_LENGTH-1:0] r_data [2];
  logic [PW-1:0]          r_pc   [2];
  logic                   r_wr;
  logic                   r_rd;
  logic [1:0]             r_cnt;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);

  // A push into a full queue is only legal when the head leaves the same cycle.
  assign w_push = i_push && (!o_full || i_pop);
  assign w_pop  = i_pop && !o_empty;

  assign o_data = o_empty ? '0 : r_data[r_rd];
  assign o_pc   = o_empty ? '0 : r_pc[r_rd];

  // Storage, pointers and occupancy; flush only resets the bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_data[i] <= '0;
        r_pc[i]   <= '0;
      end
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
      r_cnt <= 2'd0;
    end else if (i_flush) begin
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_data[r_wr] <= i_data;
        r_pc[r_wr]   <= i_pc;
        r_wr         <= ~r_wr;
      end
      if (w_pop) begin
        r_rd <= ~r_rd;
      end
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequences the PC through a combinational
// instruction memory and buffers fetched words in a two-entry queue.
// Out-of-range PCs and the fault word park the unit in HALT until reset.
module fetch_unit
  import minimicro_pkg::*;
#(
  parameter  int DATA_LENGTH = 32,
  parameter  int MEM_LENGTH  = 32,
  localparam int AW          = $clog2(MEM_LENGTH),
  localparam int PW          = AW + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   redirect_valid,
  input  logic [PW-1:0]          redirect_addr,
  output logic [AW-1:0]          imem_address,
  input  logic [DATA_LENGTH-1:0] imem_data,
  output logic                   instr_valid,
  output logic [DATA_LENGTH-1:0] instr_data,
  output logic [PW-1:0]          instr_pc,
  input  logic                   instr_ready,
  output logic                   fault,
  output logic                   busy
);

  localparam logic [DATA_LENGTH-1:0] LP_FAULT_WORD = DATA_LENGTH'(FETCH_FAULT_WORD);
  localparam logic [PW-1:0]          LP_MEM_LEN    = PW'(MEM_LENGTH);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [PW-1:0] r_pc;
  logic [PW-1:0] w_pc_nxt;
  logic          r_fault;
  logic          w_fault_nxt;

  logic          w_push;
  logic          w_pop;
  logic          w_flush;
  logic          w_full;
  logic          w_empty;
  logic [AW-1:0] w_addr;
  logic          w_in_range;
  logic          w_redirect;

  assign w_in_range = (r_pc < LP_MEM_LEN);
  assign w_redirect = (r_state == ST_RUN) && redirect_valid;

  // A redirect cancels any pop so the consumer's handshake is voided by the flush.
  assign w_pop = !w_empty && instr_ready && !w_redirect;

  fetch_queue #(
    .DATA_LENGTH (DATA_LENGTH),
    .PW          (PW)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (imem_data),
    .i_pc    (r_pc),
    .o_data  (instr_data),
    .o_pc    (instr_pc),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign instr_valid  = !w_empty;
  assign imem_address = w_addr;
  assign fault        = r_fault;
  assign busy         = (r_state == ST_RUN);

  // State, PC and sticky fault registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  // Next-state, PC update and queue control; redirect outranks everything in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_fault_nxt = r_fault;
    w_push      = 1'b0;
    w_flush     = 1'b0;
    w_addr      = '0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = '0;
        end
      end
      ST_RUN: begin
        w_addr = r_pc[AW-1:0];
        if (redirect_valid) begin
          w_flush  = 1'b1;
          w_pc_nxt = redirect_addr;
        end else if (!w_in_range) begin
          w_state_nxt = ST_HALT;
          w_fault_nxt = 1'b1;
        end else if (!w_full || w_pop) begin
          if (imem_data == LP_FAULT_WORD) begin
            w_state_nxt = ST_HALT;
            w_fault_nxt = 1'b1;
          end else begin
            w_push   = 1'b1;
            w_pc_nxt = r_pc + PW'(1);
          end
        end
      end
      ST_HALT: begin
        // Only reset leaves HALT; buffered instructions may still drain.
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a queue-based reference model and
// hand-computed checkpoints per scenario.
module tb_fetch_unit;

  localparam int DL  = 32;
  localparam int ML  = 32;
  localparam int AW  = 5;
  localparam int PW  = 6;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  typedef struct {
    logic [DL-1:0] d;
    logic [PW-1:0] pc;
  } ent_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic          redirect_valid;
  logic [PW-1:0] redirect_addr;
  logic [AW-1:0] imem_address;
  logic [DL-1:0] imem_data;
  logic          instr_valid;
  logic [DL-1:0] instr_data;
  logic [PW-1:0] instr_pc;
  logic          instr_ready;
  logic          fault;
  logic          busy;

  logic [DL-1:0] mem [ML];
  assign imem_data = mem[imem_address];

  fetch_unit #(.DATA_LENGTH(DL), .MEM_LENGTH(ML)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_address   (imem_address),
    .imem_data      (imem_data),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .fault          (fault),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int phase    = 100;
  int last_phase = -1;
  int pcyc     = 0;
  int dlog [$];

  // reference model state
  int            ms = M_IDLE;
  logic [PW-1:0] mpc = '0;
  logic          mf = 1'b0;
  ent_t          mq [$];
  logic          m_pop;
  int            m_n0;
  logic [DL-1:0] m_w;
  ent_t          m_e;
  int            e3 [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (phase %0d cycle %0d)", nm, act, exp, phase, pcyc);
    end
  endtask

  // Compare DUT against model at negedge, then advance the model by one clock.
  initial begin
    e3 = '{0, 1, 2, 3, 30, 31};
    forever begin
      @(negedge clk);
      if (phase != last_phase) begin
        last_phase = phase;
        pcyc = 0;
        dlog.delete();
      end else begin
        pcyc++;
      end

      chk("valid", instr_valid, mq.size() > 0);
      chk("data",  instr_data,  (mq.size() > 0) ? mq[0].d  : '0);
      chk("pc",    instr_pc,    (mq.size() > 0) ? mq[0].pc : '0);
      chk("fault", fault, mf);
      chk("busy",  busy,  ms == M_RUN);
      chk("imem_address", imem_address, (ms == M_RUN) ? mpc[AW-1:0] : '0);

      if (instr_valid && instr_ready) dlog.push_back(int'(instr_pc));

      // hand-computed checkpoints
      if (phase >= 100 && pcyc == 1) begin
        chk("rst_valid", instr_valid, 0);
        chk("rst_data", instr_data, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_fault", fault, 0);
        chk("rst_busy", busy, 0);
      end
      case (phase)
        1: begin
          if (pcyc == 1) chk("lat_valid_n1", instr_valid, 0);
          if (pcyc == 2) begin
            chk("lat_valid_n2", instr_valid, 1);
            chk("lat_pc0", instr_pc, 0);
            chk("lat_data0", instr_data, 32'h1000_0000);
          end
          if (pcyc == 3) chk("seq_data1", instr_data, 32'h1000_0001);
          if (pcyc == 5) chk("seq_pc3", instr_pc, 3);
          if (pcyc == 10) begin
            chk("seq_count", dlog.size(), 9);
            for (int i = 0; i < 9; i++) if (i < dlog.size()) chk("seq_order", dlog[i], i);
          end
        end
        2: begin
          if (pcyc == 5) begin
            chk("stall_valid", instr_valid, 1);
            chk("stall_head_pc", instr_pc, 0);
            chk("stall_pc_frozen", imem_address, 2);
          end
          if (pcyc == 11) begin
            chk("drain_count", dlog.size(), 6);
            for (int i = 0; i < 6; i++) if (i < dlog.size()) chk("drain_order", dlog[i], i);
          end
        end
        3: begin
          if (pcyc == 7) begin
            chk("redir_head4", instr_pc, 4);
            chk("redir_pc_frozen", imem_address, 6);
          end
          if (pcyc == 9) begin
            chk("redir_flushed", instr_valid, 0);
            chk("redir_addr30", imem_address, 30);
          end
          if (pcyc == 10) begin
            chk("redir_pc30", instr_pc, 30);
            chk("redir_data30", instr_data, 32'h1000_001E);
          end
          if (pcyc == 11) chk("redir_pc31", instr_pc, 31);
          if (pcyc == 12) begin
            chk("wrap_fault", fault, 1);
            chk("wrap_busy", busy, 0);
            chk("wrap_valid", instr_valid, 0);
          end
          if (pcyc == 13) begin
            chk("redir_count", dlog.size(), 6);
            for (int i = 0; i < 6; i++) if (i < dlog.size()) chk("redir_order", dlog[i], e3[i]);
          end
        end
        4: begin
          if (pcyc == 2) begin
            chk("oor_busy", busy, 1);
            chk("oor_fault_pre", fault, 0);
          end
          if (pcyc == 3) begin
            chk("oor_fault", fault, 1);
            chk("oor_busy_off", busy, 0);
          end
          if (pcyc == 7) begin
            chk("halt_start_ignored", busy, 0);
            chk("halt_fault_sticky", fault, 1);
            chk("oor_none_emitted", dlog.size(), 0);
          end
        end
        5: begin
          if (pcyc == 4) chk("bad_pc2", instr_pc, 2);
          if (pcyc == 5) begin
            chk("bad_fault", fault, 1);
            chk("bad_valid", instr_valid, 0);
          end
          if (pcyc == 8) begin
            chk("bad_count", dlog.size(), 3);
            for (int i = 0; i < 3; i++) if (i < dlog.size()) chk("bad_order", dlog[i], i);
          end
        end
        6: begin
          if (pcyc == 3) chk("mid_valid_pre", instr_valid, 1);
          if (pcyc == 4) begin
            chk("mid_rst_valid", instr_valid, 0);
            chk("mid_rst_busy", busy, 0);
            chk("mid_rst_addr", imem_address, 0);
          end
        end
        default: ;
      endcase

      // model step: behaviour at the coming rising edge
      m_n0  = mq.size();
      m_pop = (m_n0 > 0) && instr_ready;
      if (rst) begin
        ms = M_IDLE; mpc = '0; mf = 1'b0; mq.delete();
      end else if (ms == M_IDLE) begin
        if (start) begin ms = M_RUN; mpc = '0; end
      end else if (ms == M_RUN) begin
        if (redirect_valid) begin
          mq.delete();
          mpc = redirect_addr;
        end else begin
          if (m_pop) void'(mq.pop_front());
          if (int'(mpc) >= ML) begin
            ms = M_HALT; mf = 1'b1;
          end else if (m_n0 < 2 || m_pop) begin
            m_w = mem[mpc[AW-1:0]];
            if (m_w == 32'hDEADBEEF) begin
              ms = M_HALT; mf = 1'b1;
            end else begin
              m_e.d = m_w; m_e.pc = mpc;
              mq.push_back(m_e);
              mpc = mpc + 1;
            end
          end
        end
      end else begin
        if (m_pop) void'(mq.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int rid = 100;
  task automatic do_reset();
    phase = rid; rid++;
    rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < ML; k++) mem[k] = 32'h1000_0000 + k;
    rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_addr = '0; instr_ready = 1'b0;
    do_reset();

    // steady stream
    phase = 1; start = 1'b1; instr_ready = 1'b1;
    step(1); start = 1'b0;
    step(11);

    // back-pressure then drain
    do_reset();
    phase = 2; start = 1'b1; instr_ready = 1'b0;
    step(1); start = 1'b0;
    step(5); instr_ready = 1'b1;
    step(6);

    // redirect to 30 with pc 4,5 queued, then run off the end
    do_reset();
    phase = 3; start = 1'b1; instr_ready = 1'b1;
    step(1); start = 1'b0;
    step(5); instr_ready = 1'b0;
    step(2); redirect_valid = 1'b1; redirect_addr = 6'd30;
    step(1); redirect_valid = 1'b0; instr_ready = 1'b1;
    step(5);

    // redirect out of range; start and redirect ignored in HALT
    do_reset();
    phase = 4; start = 1'b1; instr_ready = 1'b1;
    step(1); start = 1'b0; redirect_valid = 1'b1; redirect_addr = 6'd35;
    step(1); redirect_valid = 1'b0;
    step(2); start = 1'b1;
    step(1); start = 1'b0; redirect_valid = 1'b1; redirect_addr = 6'd0;
    step(1); redirect_valid = 1'b0;
    step(2);

    // fault word at address 3
    mem[3] = 32'hDEADBEEF;
    do_reset();
    phase = 5; start = 1'b1; instr_ready = 1'b1;
    step(1); start = 1'b0;
    step(8);

    // reset in the middle of RUN with a full queue
    mem[3] = 32'h1000_0003;
    do_reset();
    phase = 6; start = 1'b1; instr_ready = 1'b0;
    step(1); start = 1'b0;
    step(2); rst = 1'b1;
    step(1); rst = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DATA_LENGTH, default 32, instruction word width.
REQ-002 Parameter MEM_LENGTH, default 32, instruction memory depth in words.
REQ-003 Localparam AW = $clog2(MEM_LENGTH) (memory address width); PW = AW+1 (PC width).
REQ-004 clk  in  1  sole clock, rising edge; one clock domain, no other clocks.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  one-cycle pulse, begins fetching at PC 0 from IDLE.
REQ-007 redirect_valid  in  1  branch/jump request.
REQ-008 redirect_addr  in  PW  new PC target.
REQ-009 imem_address  out  AW  address to instruction_memory (combinational read).
REQ-010 imem_data  in  DATA_LENGTH  return_data from instruction_memory, same cycle.
REQ-011 instr_valid  out  1  queue head holds a valid instruction.
REQ-012 instr_data  out  DATA_LENGTH  head instruction word.
REQ-013 instr_pc  out  PW  PC of head instruction.
REQ-014 instr_ready  in  1  consumer accepts head this cycle.
REQ-015 fault  out  1  sticky fetch fault flag.
REQ-016 busy  out  1  high in RUN state.

Function
REQ-017 FSM states: IDLE, RUN, HALT; encoding in shared package.
REQ-018 IDLE->RUN on start, PC loaded with 0; start in RUN or HALT ignored.
REQ-019 In RUN, fetch occurs in a cycle when the 2-entry queue is not full, or is full and popped that cycle: imem_address = PC[AW-1:0], {imem_data, PC} pushed at the clock edge, PC increments by 1.
REQ-020 Latency: start at cycle N -> first fetch in N+1 -> instr_valid=1 with instr_pc=0 in N+2.
REQ-021 Pop when instr_valid && instr_ready; instr_data/instr_pc stable while instr_valid && !instr_ready.
REQ-022 Queue full with no pop: no fetch, PC holds.
REQ-023 Redirect in RUN: queue flushed, PC <= redirect_addr at the edge; redirect beats simultaneous fetch and pop (neither takes effect); first redirected instruction valid two cycles after redirect.
REQ-024 Redirect in IDLE or HALT ignored.
REQ-025 PC >= MEM_LENGTH in RUN (sequential wrap or redirect): no fetch, RUN->HALT next edge, fault=1; queue contents remain drainable.
REQ-026 Fetched word equal to 32'hDEADBEEF: not pushed, RUN->HALT, fault=1.
REQ-027 HALT is left only via rst; fault stays 1 until rst.
REQ-028 busy = (state==RUN); imem_address = 0 outside RUN.

Reset
REQ-029 rst at any edge, including mid-fetch or mid-redirect: state=IDLE, PC=0, queue empty, instr_valid=0, instr_data=0, instr_pc=0, fault=0, busy=0.
REQ-030 rst has priority over start, redirect and pop in the same cycle.

Structure
REQ-031 Package minimicro_pkg holds the FSM state enum and the constant FETCH_FAULT_WORD = 32'hDEADBEEF.
REQ-032 Sub-module fetch_queue: 2-entry FIFO of {data, pc} with push, pop, flush, full and empty; fetch_unit holds FSM and PC only.

Verification
REQ-033 Bench instantiates fetch_unit with instruction_memory preloaded with word k = 32'h1000_0000+k.
REQ-034 Reset, start, instr_ready=1 -> instr_valid from cycle N+2; instr_pc 0,1,2,... one per cycle; instr_data 32'h1000_0000, 32'h1000_0001, ...
REQ-035 instr_ready=0 for 5 cycles after start -> exactly 2 entries held (pc 0,1), PC frozen at 2; ready=1 -> in-order drain, no loss, no duplication.
REQ-036 Redirect to 30 while queue holds pc 4,5 -> 4,5 dropped; next outputs pc 30, 31; then fault=1, state HALT, busy=0, no pc 32.
REQ-037 Redirect to 35 -> fault=1 next cycle, no instruction with pc 35 emitted; start ignored until rst.
REQ-038 Word 3 = 32'hDEADBEEF -> pc 0..2 delivered, fault=1; rst asserted mid-RUN -> all outputs zero on next edge.
